// File: rtl/mau_pkg.sv
// Shared types for the memory access unit: size encodings, FSM states,
// captured request record and the alignment check.
package mau_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_e;

    typedef struct packed {
        logic        write;
        size_e       size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Reserved size is reported the same way as a misaligned access.
    function automatic logic is_bad_access(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: is_bad_access = 1'b0;
            SZ_HALF: is_bad_access = lo[0];
            SZ_WORD: is_bad_access = |lo;
            default: is_bad_access = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane merge for sub-word stores and lane extraction/extension for loads.
// Latency: combinational.
// Backpressure: none.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    assign byte_shift = mem_word >> {lane, 3'b000};
    assign half_shift = mem_word >> {lane[1], 4'b0000};

    always_comb begin
        merged_word = mem_word;
        case (size)
            SZ_BYTE: merged_word[{lane, 3'b000} +: 8]     = store_data[7:0];
            SZ_HALF: merged_word[{lane[1], 4'b0000} +: 16] = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

    always_comb begin
        load_data = mem_word;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'h0, byte_shift[7:0]}
                                             : {{24{byte_shift[7]}}, byte_shift[7:0]};
            SZ_HALF: load_data = is_unsigned ? {16'h0, half_shift[15:0]}
                                             : {{16{half_shift[15]}}, half_shift[15:0]};
            default: load_data = mem_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store unit over a word-wide synchronous-write memory.
// Latency: load/word store 2 cycles, sub-word store (read-modify-write) 3, error 1.
// Backpressure: req_ready only in IDLE; responses are single-cycle pulses with no stall.
module mem_access_unit
    import mau_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] read_data
);

    state_e      state;
    req_t        cap;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] merged_word;
    logic [31:0] load_data;
    size_e       in_size;

    assign in_size   = size_e'(req_size);
    assign req_ready = (state == IDLE);
    assign address   = {cap.addr[31:2], 2'b00};
    // Gate strobes with reset so an access in flight never touches memory.
    assign mem_read  = mem_read_q  & ~reset;
    assign mem_write = mem_write_q & ~reset;

    mau_lane_align u_lane_align (
        .mem_word    (read_data),
        .store_data  (cap.wdata),
        .size        (cap.size),
        .lane        (cap.addr[1:0]),
        .is_unsigned (cap.is_unsigned),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cap         <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            write_data  <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        cap <= '{write: req_write, size: in_size, is_unsigned: req_unsigned,
                                 addr: req_addr, wdata: req_wdata};
                        if (is_bad_access(in_size, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_write) begin
                            state      <= LOAD;
                            mem_read_q <= 1'b1;
                        end else if (in_size == SZ_WORD) begin
                            state       <= STORE;
                            mem_write_q <= 1'b1;
                            write_data  <= req_wdata;
                        end else begin
                            state      <= RMW_RD;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    mem_read_q <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= load_data;
                end
                STORE: begin
                    mem_write_q <= 1'b0;
                    state       <= RESP;
                    resp_valid  <= 1'b1;
                    resp_error  <= 1'b0;
                    resp_rdata  <= '0;
                end
                RMW_RD: begin
                    // The merged word is registered here; RMW_WR only drives it out.
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b1;
                    write_data  <= merged_word;
                    state       <= RMW_WR;
                end
                RMW_WR: begin
                    mem_write_q <= 1'b0;
                    state       <= RESP;
                    resp_valid  <= 1'b1;
                    resp_error  <= 1'b0;
                    resp_rdata  <= '0;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    resp_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a 16-word behavioural memory.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;

    logic [31:0] mem [0:15];
    logic        mem_init;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [18];
    vec_t bvec [4];
    logic [31:0] bexp [4];

    mem_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .address      (address),
        .write_data   (write_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .read_data    (read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign read_data = mem[address[5:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h80706050;
        end else if (mem_write) begin
            mem[address[5:2]] <= write_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_fields(input vec_t v);
        req_write    = v.wr;
        req_size     = v.sz;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
    endtask

    task automatic do_req(input vec_t v, input int idx);
        int          wt;
        int          lat;
        int          rd;
        int          wr;
        logic        got;
        logic        excl;
        logic        addr_ok;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        err;
        lat = 0; rd = 0; wr = 0; got = 1'b0; excl = 1'b0; addr_ok = 1'b1;
        wd = 32'h0; rdata = 32'h0; err = 1'b0; wt = 0;
        @(negedge clk);
        drive_fields(v);
        req_valid = 1'b1;
        while (!req_ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        if (!req_ready) begin
            n_chk++; n_err++;
            $display("FAIL v%0d_ready: got timeout required req_ready", idx);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            lat = c;
            if (mem_read) rd++;
            if (mem_write) begin
                wr++;
                wd = write_data;
            end
            if (mem_read && mem_write) excl = 1'b1;
            if ((mem_read || mem_write) && address !== (v.addr & ~32'h3)) addr_ok = 1'b0;
            if (resp_valid) begin
                got   = 1'b1;
                rdata = resp_rdata;
                err   = resp_error;
                break;
            end
        end
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL v%0d_resp: got timeout required resp_valid", idx);
            return;
        end
        chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
        chk($sformatf("v%0d_error", idx), {31'h0, err}, {31'h0, v.exp_err});
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_reads", idx), rd, v.exp_rd);
        chk($sformatf("v%0d_writes", idx), wr, v.exp_wr);
        chk($sformatf("v%0d_rw_exclusive", idx), {31'h0, excl}, 32'h0);
        chk($sformatf("v%0d_address", idx), {31'h0, addr_ok}, 32'h1);
        if (v.exp_wr != 0) chk($sformatf("v%0d_write_data", idx), wd, v.exp_wd);
    endtask

    initial begin
        logic seen;
        int   k;
        int   rc;
        logic pend;
        logic overlap;

        //           wr sz     uns addr    wdata          rdata          err lat rd wr wd
        vecs[0]  = '{0, 2'b10, 0, 32'd8,  32'h0,         32'h80706050, 0, 2, 1, 0, 32'h0};
        vecs[1]  = '{0, 2'b00, 0, 32'd11, 32'h0,         32'hFFFFFF80, 0, 2, 1, 0, 32'h0};
        vecs[2]  = '{0, 2'b00, 1, 32'd11, 32'h0,         32'h00000080, 0, 2, 1, 0, 32'h0};
        vecs[3]  = '{0, 2'b01, 0, 32'd10, 32'h0,         32'hFFFF8070, 0, 2, 1, 0, 32'h0};
        vecs[4]  = '{0, 2'b01, 1, 32'd8,  32'h0,         32'h00006050, 0, 2, 1, 0, 32'h0};
        vecs[5]  = '{0, 2'b00, 0, 32'd9,  32'h0,         32'h00000060, 0, 2, 1, 0, 32'h0};
        vecs[6]  = '{1, 2'b00, 0, 32'd9,  32'hFFFFFFAB,  32'h0,        0, 3, 1, 1, 32'h8070AB50};
        vecs[7]  = '{0, 2'b10, 0, 32'd8,  32'h0,         32'h8070AB50, 0, 2, 1, 0, 32'h0};
        vecs[8]  = '{0, 2'b10, 0, 32'd10, 32'h0,         32'h0,        1, 1, 0, 0, 32'h0};
        vecs[9]  = '{1, 2'b01, 0, 32'd13, 32'h1111,      32'h0,        1, 1, 0, 0, 32'h0};
        vecs[10] = '{0, 2'b11, 0, 32'd12, 32'h0,         32'h0,        1, 1, 0, 0, 32'h0};
        vecs[11] = '{1, 2'b10, 0, 32'd12, 32'hDEADBEEF,  32'h0,        0, 2, 0, 1, 32'hDEADBEEF};
        vecs[12] = '{0, 2'b10, 0, 32'd12, 32'h0,         32'hDEADBEEF, 0, 2, 1, 0, 32'h0};
        vecs[13] = '{1, 2'b01, 0, 32'd14, 32'hFFFF1234,  32'h0,        0, 3, 1, 1, 32'h1234BEEF};
        vecs[14] = '{0, 2'b01, 1, 32'd14, 32'h0,         32'h00001234, 0, 2, 1, 0, 32'h0};
        vecs[15] = '{0, 2'b00, 0, 32'd13, 32'h0,         32'hFFFFFFBE, 0, 2, 1, 0, 32'h0};
        vecs[16] = '{1, 2'b00, 0, 32'd12, 32'h00000055,  32'h0,        0, 3, 1, 1, 32'h1234BE55};
        vecs[17] = '{0, 2'b10, 0, 32'd12, 32'h0,         32'h1234BE55, 0, 2, 1, 0, 32'h0};

        bvec[0] = '{1, 2'b10, 0, 32'd0, 32'h11223344, 32'h0, 0, 0, 0, 0, 32'h0};
        bvec[1] = '{0, 2'b10, 0, 32'd0, 32'h0,        32'h0, 0, 0, 0, 0, 32'h0};
        bvec[2] = '{1, 2'b00, 0, 32'd1, 32'h00000099, 32'h0, 0, 0, 0, 0, 32'h0};
        bvec[3] = '{0, 2'b00, 1, 32'd1, 32'h0,        32'h0, 0, 0, 0, 0, 32'h0};
        bexp[0] = 32'h0;
        bexp[1] = 32'h11223344;
        bexp[2] = 32'h0;
        bexp[3] = 32'h00000099;

        reset = 1'b1; mem_init = 1'b1; req_valid = 1'b0;
        drive_fields(vecs[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mem_init = 1'b0;
        @(negedge clk);
        chk("reset_req_ready",  {31'h0, req_ready},  32'h1);
        chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset_resp_rdata", resp_rdata,          32'h0);
        chk("reset_resp_error", {31'h0, resp_error}, 32'h0);
        chk("reset_mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);

        for (int i = 0; i < 18; i++) do_req(vecs[i], i);

        // Halfword store at addr 8 with reset landing in the RMW_WR cycle.
        @(negedge clk);
        drive_fields('{1, 2'b01, 0, 32'd8, 32'h1234, 32'h0, 0, 0, 0, 0, 32'h0});
        req_valid = 1'b1;
        chk("rst_rmw_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_rmw_rd_strobe", {30'h0, mem_read, mem_write}, 32'h2);
        @(negedge clk);
        chk("rst_rmw_wr_strobe", {30'h0, mem_read, mem_write}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_rmw_gated", {30'h0, mem_read, mem_write}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_rmw_ready_after", {31'h0, req_ready}, 32'h1);
        chk("rst_rmw_rdata_clr", resp_rdata, 32'h0);
        seen = resp_valid;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("rst_rmw_no_resp", {31'h0, seen}, 32'h0);
        chk("rst_rmw_mem_kept", mem[2], 32'h8070AB50);

        // Continuous req_valid with alternating stores and loads.
        k = 0; rc = 0; pend = 1'b0; overlap = 1'b0;
        @(negedge clk);
        drive_fields(bvec[0]);
        req_valid = 1'b1;
        if (req_ready) pend = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (rc < 4) begin
                    chk($sformatf("b2b_rdata%0d", rc), resp_rdata, bexp[rc]);
                    chk($sformatf("b2b_error%0d", rc), {31'h0, resp_error}, 32'h0);
                end
                rc++;
                if (req_ready) overlap = 1'b1;
            end
            if (pend) begin
                k++;
                pend = 1'b0;
                if (k < 4) drive_fields(bvec[k]);
                else req_valid = 1'b0;
            end
            if (k < 4 && req_ready && req_valid) pend = 1'b1;
        end
        chk("b2b_accepted", k, 4);
        chk("b2b_responses", rc, 4);
        chk("b2b_ready_in_resp", {31'h0, overlap}, 32'h0);
        chk("b2b_mem0", mem[0], 32'h11229944);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
